// File: rtl/ofm_collector.sv
// Receive-side endpoint of the convolution OFM stream: captures one frame into a
// register file, tracks running max/sum, then drains it over valid/ready.
module ofm_collector #(
   parameter int DATA_W = 13,
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     out_valid,
   input  logic [DATA_W-1:0]        Out_OFM,
   output logic                     rd_valid,
   input  logic                     rd_ready,
   output logic [DATA_W-1:0]        rd_data,
   output logic                     frame_done,
   output logic [DATA_W-1:0]        max_val,
   output logic [DATA_W+ADDR_W-1:0] sum_val,
   output logic                     busy,
   output logic                     err_ovf
);

   localparam int SUM_W = DATA_W + ADDR_W;
   localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_DRAIN} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   logic [DATA_W-1:0]   max_q, max_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic                wr_en;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         wr_cnt_q <= '0;
         rd_ptr_q <= '0;
         max_q    <= '0;
         sum_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         wr_cnt_q <= wr_cnt_d;
         rd_ptr_q <= rd_ptr_d;
         max_q    <= max_d;
         sum_q    <= sum_d;
         done_q   <= done_d;
         err_q    <= err_d;
      end
   end

   // Buffer contents are don't-care after reset, so no reset term here.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_cnt_q] <= Out_OFM;
   end

   always_comb begin
      state_d  = state_q;
      wr_cnt_d = wr_cnt_q;
      rd_ptr_d = rd_ptr_q;
      max_d    = max_q;
      sum_d    = sum_q;
      done_d   = 1'b0;
      err_d    = err_q;
      wr_en    = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (out_valid) begin
               wr_en    = 1'b1;
               wr_cnt_d = ADDR_W'(1);
               max_d    = Out_OFM;
               sum_d    = SUM_W'(Out_OFM);
               state_d  = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (out_valid) begin
               wr_en    = 1'b1;
               wr_cnt_d = wr_cnt_q + ADDR_W'(1);
               max_d    = (Out_OFM > max_q) ? Out_OFM : max_q;
               sum_d    = sum_q + SUM_W'(Out_OFM);
               if (wr_cnt_q == LAST) begin
                  done_d   = 1'b1;
                  wr_cnt_d = '0;
                  rd_ptr_d = '0;
                  state_d  = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            if (out_valid) err_d = 1'b1;
            if (rd_ready) begin
               rd_ptr_d = rd_ptr_q + ADDR_W'(1);
               if (rd_ptr_q == LAST) state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign rd_valid   = (state_q == S_DRAIN);
   assign rd_data    = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign frame_done = done_q;
   assign max_val    = max_q;
   assign sum_val    = sum_q;
   assign busy       = (state_q != S_IDLE);
   assign err_ovf    = err_q;

endmodule

// File: doc/ofm_collector.md
Name: ofm_collector

Overview:
- Receive-side endpoint of the Convolution output stream.
- Captures one frame of DEPTH consecutive Out_OFM samples qualified by out_valid into a register-file buffer, and keeps a running max and sum for the frame.
- Drains the frame to a downstream consumer over a valid/ready handshake.
- Sits between the Convolution core and the post-processing or host-readback logic.

Parameters:
- DATA_W, 13, width of each OFM sample (matches Out_OFM).
- DEPTH, 16, OFM samples per frame; power of two, ≥2.
- ADDR_W, 4, log2(DEPTH).

Ports:
- clk  input  1  single clock; all logic on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- out_valid  input  1  sample qualifier from the Convolution core.
- Out_OFM  input  DATA_W  OFM sample; unsigned.
- rd_valid  output  1  drain data valid.
- rd_ready  input  1  downstream accepts rd_data.
- rd_data  output  DATA_W  drained sample.
- frame_done  output  1  one-cycle pulse when the last sample of a frame is written.
- max_val  output  DATA_W  maximum sample of the current/last frame.
- sum_val  output  DATA_W+ADDR_W  sum of samples of the current/last frame.
- busy  output  1  high in CAPTURE or DRAIN.
- err_ovf  output  1  sticky: a sample arrived while in DRAIN.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values: all outputs 0. State IDLE; wr_cnt=0, rd_ptr=0; buffer contents don't-care.
- States and transitions:
  - IDLE: out_valid=1 → mem[0]<=Out_OFM, wr_cnt<=1, max<=Out_OFM, sum<=Out_OFM, go CAPTURE. This discards the previous frame's max/sum.
  - CAPTURE: out_valid=1 → mem[wr_cnt]<=Out_OFM; wr_cnt++; max<=max(max,Out_OFM); sum<=sum+Out_OFM.
  - CAPTURE, out_valid=0: hold, with no timeout; gaps inside a frame are legal.
  - CAPTURE, write at wr_cnt==DEPTH-1: frame_done=1 in the next cycle only; wr_cnt<=0; rd_ptr<=0; go DRAIN.
  - DRAIN: rd_valid=1; rd_data=mem[rd_ptr], combinational from registered state. rd_valid&&rd_ready → rd_ptr++.
  - DRAIN, accept at rd_ptr==DEPTH-1: rd_valid deasserts next cycle; go IDLE.
  - rd_data=0 whenever rd_valid=0.
- Handshake rules:
  - Once rd_valid is high, rd_valid and rd_data stay stable until accepted.
  - rd_ready may be held high; then one sample drains per cycle, DEPTH cycles total.
- Latency:
  - Last captured sample to frame_done and rd_valid rising: 1 cycle, same cycle for both.
  - Minimum frame period: 2×DEPTH cycles.
- Arithmetic and widths:
  - Unsigned compare.
  - sum width DATA_W+ADDR_W; it cannot overflow for DEPTH samples of max value.
  - max_val and sum_val update combinationally-registered each capture. They are valid and held from frame_done until the next frame's first sample.
- Boundary conditions:
  - out_valid in DRAIN: sample dropped, err_ovf<=1 (sticky until rst); drain continues unaffected.
  - out_valid in the same cycle as the final DRAIN accept: still DRAIN, so dropped and err_ovf set. The next-cycle sample starts a new frame.
  - rst asserted mid-CAPTURE or mid-DRAIN: immediate return to IDLE. Outputs clear asynchronously; partial frame lost.
  - busy=1 exactly in CAPTURE and DRAIN.

Test Plan:
- Reset, then DEPTH=16 back-to-back samples 1..16, rd_ready=1:
  - frame_done pulses 1 cycle after sample 16.
  - rd_data drains 1..16 on consecutive cycles.
  - max_val=16, sum_val=136, err_ovf=0.
- Samples with gaps (out_valid toggling 1,0,0,1,…), values all 8191:
  - 16 captures complete regardless of gaps.
  - sum_val=131056, max_val=8191, no overflow.
- Backpressure: rd_ready low for 5 cycles at rd_ptr=3:
  - rd_valid stays 1 and rd_data holds mem[3] throughout.
  - Drain resumes with 4..16; total accepted = 16.
- Sample 0x0AA during DRAIN:
  - err_ovf=1 and stays 1.
  - Drained data unchanged.
  - Next frame after return to IDLE captures normally.
- rst pulse after 7 captures:
  - busy=0 and all outputs 0 asynchronously.
  - Fresh frame of 16×5 → sum_val=80, max_val=5.
- Two frames back-to-back with the second starting the cycle after the final accept:
  - Second frame fully captured.
  - max_val/sum_val reflect only the second frame.
